// File: rtl/hp_pkg.sv
// hp_pkg -- shared definitions for the half-precision multiplier datapath.
//
// Holds the binary16 field geometry used by the multiplier stage, the
// class-flag bit positions, the 6-bit class vector type and the 23-bit
// result-queue entry type, plus a one-hot test used when classifying pushes.
package hp_pkg;

  // binary16 geometry (shared with the multiplier stage)
  localparam int HP_W      = 16;
  localparam int HP_EXP_W  = 5;
  localparam int HP_MAN_W  = 10;
  localparam int HP_BIAS   = 15;

  // Class-flag bit positions inside the 6-bit class vector
  localparam int FLAG_NORMAL    = 0;
  localparam int FLAG_SUBNORMAL = 1;
  localparam int FLAG_ZERO      = 2;
  localparam int FLAG_INFINITY  = 3;
  localparam int FLAG_QNAN      = 4;
  localparam int FLAG_SNAN      = 5;
  localparam int NUM_CLASSES    = 6;

  // Sticky vector: class bits plus the protocol-error bit on top
  localparam int STICKY_PROTO_ERR = 6;
  localparam int STICKY_W         = 7;

  typedef logic [NUM_CLASSES-1:0] hp_class_t;

  // One queue entry: product, its class flags, and whether the flags
  // arrived malformed (not one-hot). 1 + 6 + 16 = 23 bits.
  typedef struct packed {
    logic            proto_err;
    hp_class_t       flags;
    logic [HP_W-1:0] p;
  } hp_entry_t;

  localparam int ENTRY_W = $bits(hp_entry_t);

  // Exactly one bit set
  function automatic logic is_onehot(input hp_class_t f);
    return (f != '0) && ((f & (f - hp_class_t'(1))) == '0);
  endfunction

endpackage

// File: rtl/hp_fifo.sv
// hp_fifo -- storage array plus read/write pointers for the result queue.
//
// Ports:
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset (pointers/level only)
//   push_i   : write wdata_i at the tail this cycle (ignored when full)
//   pop_i    : advance the head this cycle (ignored when empty)
//   wdata_i  : entry to store
//   rdata_o  : head entry, read combinationally from the array
//   level_o  : current occupancy, 0..DEPTH
//   full_o   : level_o == DEPTH
//   empty_o  : level_o == 0
//
// DEPTH must be a power of two so the pointers wrap by natural overflow.
// Full and empty come from the occupancy count, never from pointer equality.
module hp_fifo #(
  parameter int WIDTH = 23,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             push_ok, pop_ok;

  assign full_o  = (level_q == LVL_W'(DEPTH));
  assign empty_o = (level_q == '0);

  // Guard here too so the block is safe even if a caller ignores full/empty
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (push_ok) wptr_d = wptr_q + PTR_W'(1);
    if (pop_ok)  rptr_d = rptr_q + PTR_W'(1);
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

  // Storage is deliberately not reset; the level count makes stale
  // contents unreachable.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q];
  assign level_o = level_q;

endmodule

// File: rtl/hp_mul_result_q.sv
// hp_mul_result_q -- result queue behind the binary16 multiplier stage.
//
// Buffers {product, class flags} in a DEPTH-entry FIFO, accumulates the
// classes seen into a sticky vector and flags any push whose class vector
// is not one-hot as a protocol error (the entry is still stored as given).
//
// Ports:
//   clk, rst_n          : clock (rising edge) and async active-low reset
//   in_valid/in_ready   : upstream handshake; in_ready = not full
//   in_p, in_flags      : product and {snan,qnan,inf,zero,sub,normal}
//   out_valid/out_ready : downstream handshake; out_valid = not empty
//   out_p, out_flags    : head entry
//   sticky              : {proto_err, class bits} since reset / sticky_clr
//   sticky_clr          : synchronous clear of sticky (and stats)
//   stats_cnt           : only with HP_MUL_STATS_EN; per-class saturating
//                         16-bit push counters, index = class bit position
//   level               : occupancy 0..DEPTH
//
// Optional feature macro: HP_MUL_STATS_EN.
// DEPTH: power of two, 2..16.
module hp_mul_result_q
  import hp_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [15:0]            in_p,
  input  logic [5:0]             in_flags,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [15:0]            out_p,
  output logic [5:0]             out_flags,
  output logic [6:0]             sticky,
  input  logic                   sticky_clr,
`ifdef HP_MUL_STATS_EN
  output logic [5:0][15:0]       stats_cnt,
`endif
  output logic [$clog2(DEPTH):0] level
);

  hp_entry_t          push_entry;
  hp_entry_t          head_entry;
  logic               push, pop;
  logic               fifo_full, fifo_empty;
  logic [STICKY_W-1:0] sticky_q, sticky_d;
  logic               unused_head_err;

  // A pop in the same cycle does not free a slot for a push: in_ready
  // depends on the current level only.
  assign in_ready  = !fifo_full;
  assign out_valid = !fifo_empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign push_entry.proto_err = !is_onehot(in_flags);
  assign push_entry.flags     = in_flags;
  assign push_entry.p         = in_p;

  hp_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (push_entry),
    .rdata_o (head_entry),
    .level_o (level),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign out_p     = head_entry.p;
  assign out_flags = head_entry.flags;
  // The stored error bit travels with the entry but has no output today
  assign unused_head_err = head_entry.proto_err;

  // Clear first, then OR in this cycle's push so a same-cycle push survives
  always_comb begin
    sticky_d = sticky_clr ? '0 : sticky_q;
    if (push) begin
      sticky_d[NUM_CLASSES-1:0] = sticky_d[NUM_CLASSES-1:0] | in_flags;
      if (push_entry.proto_err) sticky_d[STICKY_PROTO_ERR] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sticky_q <= '0;
    else        sticky_q <= sticky_d;
  end

  assign sticky = sticky_q;

`ifdef HP_MUL_STATS_EN
  // Per-class push counters. Same ordering as sticky: a clear coinciding
  // with a counted push leaves the counter at 1.
  for (genvar gi = 0; gi < NUM_CLASSES; gi++) begin : g_stats
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d = sticky_clr ? 16'h0000 : cnt_q;
      if (push && in_flags[gi] && (cnt_d != 16'hFFFF)) cnt_d = cnt_d + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= 16'h0000;
      else        cnt_q <= cnt_d;
    end

    assign stats_cnt[gi] = cnt_q;
  end
`endif

endmodule
